sd_spi: RTL and testbench

SPI master that executes the SD-card commands issued by the memory/port mapper through ports 0Fh/1Fh. It accepts a command on the rising edge of `sd_signal`, drives the card's SPI pins in mode 0, and returns `sd_din`, `sd_busy` and `sd_timeout` to the port-read mux. It sits between the Z80 port decoder and the DE0 SD socket, in the CPU clock domain.

---
 rtl/sd_spi.sv | 190 +++++++++++++++++++
 tb/tb_sd_spi.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi.sv
// -----------------------------------------------------------------------------
// sd_spi -- SPI master (mode 0) that executes SD-card commands from the
// port mapper (ports 0Fh/1Fh) and returns status/data to the port-read mux.
//
// Parameters
//   SPI_HALF  SCLK half-period in clock cycles (>=1); one bit = 2*SPI_HALF
//   TIMEOUT   cycles without an accepted command before sd_timeout sets (>=2)
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset_n     in   asynchronous active-low reset
//   sd_signal   in   command strobe, command taken on its 0->1 transition
//   sd_cmd      in   [1:0] 0 init, 1 byte exchange, 2 CS assert, 3 CS release
//   sd_out      in   [7:0] byte to transmit for command 1
//   sd_din      out  [7:0] last byte received from the card
//   sd_busy     out  high while a command executes
//   sd_timeout  out  high once TIMEOUT cycles passed since last accepted command
//   spi_sclk    out  SPI clock, idle low
//   spi_mosi    out  SPI data to card, idle high
//   spi_miso    in   SPI data from card
//   spi_cs_n    out  card select, active low
// -----------------------------------------------------------------------------
module sd_spi #(
  parameter int unsigned SPI_HALF = 64,
  parameter int unsigned TIMEOUT  = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int unsigned DW = (SPI_HALF > 1) ? $clog2(SPI_HALF) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DIV_RELOAD = DW'(SPI_HALF - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_XFER
  } state_t;

  state_t        state_q, state_d;
  logic          prev_q, prev_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    bits_q, bits_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    din_q, din_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic start;
  logic accept;
  logic half_tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      bits_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      shift_q <= '1;
      din_q   <= '1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = sd_signal;
    busy_d  = busy_q;
    div_d   = div_q;
    bits_d  = bits_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    shift_d = shift_q;
    din_d   = din_q;

    start     = sd_signal & ~prev_q;
    // A strobe arriving while busy is dropped, including its timeout clear.
    accept    = start & ~busy_q;
    half_tick = (div_q == '0);

    if (accept)
      tmo_d = '0;
    else if (tmo_q == TMO_MAX)
      tmo_d = tmo_q;
    else
      tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // The one-cycle busy of cmd 2/3 is released here on the next cycle.
        busy_d = 1'b0;
        if (accept) begin
          busy_d = 1'b1;
          case (sd_cmd)
            2'd0: begin
              state_d = S_INIT;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b1;
              bits_d  = 7'd80;
              div_d   = DIV_RELOAD;
            end
            2'd1: begin
              state_d = S_XFER;
              shift_d = sd_out;
              mosi_d  = sd_out[7];
              bits_d  = 7'd8;
              div_d   = DIV_RELOAD;
            end
            2'd2:    cs_n_d = 1'b0;
            default: cs_n_d = 1'b1;
          endcase
        end
      end

      S_INIT, S_XFER: begin
        if (half_tick) begin
          div_d = DIV_RELOAD;
          if (!sclk_q) begin
            // Rising edge: sample MISO on the same edge that raises SCLK.
            sclk_d = 1'b1;
            if (state_q == S_XFER)
              shift_d = {shift_q[6:0], spi_miso};
          end else begin
            // Falling edge: shift already moved, so bit 7 is the next to send.
            sclk_d = 1'b0;
            bits_d = bits_q - 1'b1;
            if (bits_q == 7'd1) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              if (state_q == S_XFER) begin
                din_d  = shift_q;
                mosi_d = 1'b1;
              end
            end else if (state_q == S_XFER) begin
              mosi_d = shift_q[7];
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sd_din     = din_q;
  assign sd_busy    = busy_q;
  assign sd_timeout = (tmo_q == TMO_MAX);
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;

endmodule

// File: tb/tb_sd_spi.sv
// -----------------------------------------------------------------------------
// tb_sd_spi -- self-checking bench for sd_spi (SPI_HALF=2, TIMEOUT=100).
// A card model answers on MISO (changing on falling SCLK) and records MOSI at
// each rising SCLK; expected values come from command-level rules.
// -----------------------------------------------------------------------------
module tb_sd_spi;

  localparam int unsigned HALF = 2;
  localparam int unsigned TMO  = 100;
  localparam int          XFER_CYC = 16 * HALF;
  localparam int          INIT_CYC = 160 * HALF;

  logic       clock;
  logic       reset_n;
  logic       sd_signal;
  logic [1:0] sd_cmd;
  logic [7:0] sd_out;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  int errors = 0;
  int checks = 0;

  sd_spi #(.SPI_HALF(HALF), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sd_signal  (sd_signal),
    .sd_cmd     (sd_cmd),
    .sd_out     (sd_out),
    .sd_din     (sd_din),
    .sd_busy    (sd_busy),
    .sd_timeout (sd_timeout),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Card model
  logic [7:0] card_byte;
  int         card_idx;
  int         pulses;
  logic       mosi_seen[$];

  always @(negedge spi_sclk) begin
    if (card_idx < 7) begin
      card_idx = card_idx + 1;
      spi_miso = card_byte[7 - card_idx];
    end
  end

  always @(posedge spi_sclk) begin
    pulses = pulses + 1;
    mosi_seen.push_back(spi_mosi);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_card(input logic [7:0] resp);
    card_byte = resp;
    card_idx  = 0;
    spi_miso  = resp[7];
    pulses    = 0;
    mosi_seen.delete();
  endtask

  // Strobe a command; returns positioned just after edge T.
  task automatic issue(input logic [1:0] cmd, input logic [7:0] data);
    sd_cmd    = cmd;
    sd_out    = data;
    sd_signal = 1'b1;
    tick();
    sd_signal = 1'b0;
  endtask

  // Byte exchange; reports busy length and whether CS stayed low throughout.
  task automatic run_xfer(input logic [7:0] out, input logic [7:0] resp,
                          output int cyc, output bit cs_low);
    load_card(resp);
    issue(2'd1, out);
    cyc    = 0;
    cs_low = (spi_cs_n == 1'b0);
    while (sd_busy && cyc < 2000) begin
      tick();
      cyc = cyc + 1;
      if (spi_cs_n !== 1'b0) cs_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    sd_signal = 1'b0;
    sd_cmd    = 2'd0;
    sd_out    = 8'h00;
    load_card(8'hFF);
    #12;
    checks++;
    if ({sd_din, sd_busy, sd_timeout, spi_sclk, spi_mosi, spi_cs_n} !== {8'hFF, 5'b00011}) begin
      errors++;
      $display("FAIL reset_values got din=%h busy=%b tmo=%b sclk=%b mosi=%b cs_n=%b want din=ff busy=0 tmo=0 sclk=0 mosi=1 cs_n=1",
               sd_din, sd_busy, sd_timeout, spi_sclk, spi_mosi, spi_cs_n);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_timeout_from_reset();
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    checks++;
    if (sd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b want 0 at cycle %0d", sd_timeout, TMO - 1);
    end
    tick();
    checks++;
    if (sd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_at_limit got %b want 1 at cycle %0d", sd_timeout, TMO);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (sd_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_saturate got %b want 1", sd_timeout);
    end
  endtask

  task automatic test_cs_and_exchange();
    int cyc;
    bit cs_low;
    bit bit_ok;
    issue(2'd2, 8'h00);
    checks++;
    if ({spi_cs_n, sd_busy, sd_timeout} !== 3'b010) begin
      errors++;
      $display("FAIL cmd2_at_T got cs_n=%b busy=%b tmo=%b want cs_n=0 busy=1 tmo=0",
               spi_cs_n, sd_busy, sd_timeout);
    end
    tick();
    checks++;
    if (sd_busy !== 1'b0) begin
      errors++;
      $display("FAIL cmd2_busy_len got busy=%b want 0 at T+1", sd_busy);
    end
    run_xfer(8'hA5, 8'h3C, cyc, cs_low);
    checks++;
    if (cyc !== XFER_CYC) begin
      errors++;
      $display("FAIL xfer_a5_busy got %0d cycles want %0d", cyc, XFER_CYC);
    end
    checks++;
    if (sd_din !== 8'h3C) begin
      errors++;
      $display("FAIL xfer_a5_din got %h want 3c", sd_din);
    end
    bit_ok = (mosi_seen.size() == 8);
    for (int i = 0; i < 8 && bit_ok; i++)
      if (mosi_seen[i] !== 1'((8'hA5 >> (7 - i)) & 1)) bit_ok = 1'b0;
    checks++;
    if (!bit_ok || !cs_low || spi_sclk !== 1'b0 || spi_mosi !== 1'b1) begin
      errors++;
      $display("FAIL xfer_a5_pins got bits_ok=%b nbits=%0d cs_low=%b sclk=%b mosi=%b want 1 8 1 0 1",
               bit_ok, mosi_seen.size(), cs_low, spi_sclk, spi_mosi);
    end
  endtask

  task automatic test_random_exchanges();
    int cyc;
    bit cs_low;
    logic [7:0] out, resp;
    logic [7:0] got_bits;
    for (int n = 0; n < 6; n++) begin
      out  = 8'($urandom);
      resp = 8'($urandom);
      run_xfer(out, resp, cyc, cs_low);
      got_bits = '0;
      for (int i = 0; i < mosi_seen.size() && i < 8; i++)
        got_bits = 8'(got_bits * 2 + 8'(mosi_seen[i]));
      checks++;
      if (cyc !== XFER_CYC || sd_din !== resp || got_bits !== out || pulses !== 8) begin
        errors++;
        $display("FAIL rand_xfer%0d got cyc=%0d din=%h mosi=%h pulses=%0d want cyc=%0d din=%h mosi=%h pulses=8",
                 n, cyc, sd_din, got_bits, pulses, XFER_CYC, resp, out);
      end
    end
  endtask

  task automatic test_init();
    int cyc;
    bit ok_pins;
    logic [7:0] din_before;
    int ones;
    din_before = sd_din;
    load_card(8'h00);
    issue(2'd0, 8'h00);
    cyc     = 0;
    ok_pins = (spi_cs_n === 1'b1 && spi_mosi === 1'b1);
    while (sd_busy && cyc < 2000) begin
      tick();
      cyc = cyc + 1;
      if (spi_cs_n !== 1'b1 || spi_mosi !== 1'b1) ok_pins = 1'b0;
    end
    ones = 0;
    foreach (mosi_seen[i]) if (mosi_seen[i] === 1'b1) ones++;
    checks++;
    if (cyc !== INIT_CYC) begin
      errors++;
      $display("FAIL init_busy got %0d cycles want %0d", cyc, INIT_CYC);
    end
    checks++;
    if (pulses !== 80 || ones !== 80 || !ok_pins) begin
      errors++;
      $display("FAIL init_pins got pulses=%0d mosi_ones=%0d pins_ok=%b want 80 80 1", pulses, ones, ok_pins);
    end
    checks++;
    if (sd_din !== din_before) begin
      errors++;
      $display("FAIL init_din got %h want %h", sd_din, din_before);
    end
  endtask

  task automatic test_long_strobe();
    int cyc;
    int extra_busy;
    logic [7:0] resp;
    resp = 8'($urandom);
    load_card(resp);
    sd_cmd    = 2'd1;
    sd_out    = 8'($urandom);
    sd_signal = 1'b1;
    tick();
    cyc = 0;
    while (sd_busy && cyc < 2000) begin
      // high for edges T..T+4, second rising edge at T+10 during transfer
      sd_signal = ((cyc + 1) <= 4) || ((cyc + 1) >= 10 && (cyc + 1) <= 11);
      tick();
      cyc = cyc + 1;
    end
    sd_signal  = 1'b0;
    extra_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sd_busy) extra_busy++;
    end
    checks++;
    if (cyc !== XFER_CYC || pulses !== 8 || extra_busy !== 0 || sd_din !== resp) begin
      errors++;
      $display("FAIL long_strobe got cyc=%0d pulses=%0d extra_busy=%0d din=%h want %0d 8 0 %h",
               cyc, pulses, extra_busy, sd_din, XFER_CYC, resp);
    end
  endtask

  task automatic test_cmd3_timeout();
    issue(2'd2, 8'h00);
    tick();
    for (int i = 0; i < int'(TMO) + 5; i++) tick();
    checks++;
    if (sd_timeout !== 1'b1 || spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout got tmo=%b cs_n=%b want 1 0", sd_timeout, spi_cs_n);
    end
    issue(2'd3, 8'h00);
    checks++;
    if ({sd_timeout, spi_cs_n, sd_busy} !== 3'b011) begin
      errors++;
      $display("FAIL cmd3_at_T got tmo=%b cs_n=%b busy=%b want 0 1 1", sd_timeout, spi_cs_n, sd_busy);
    end
    tick();
    checks++;
    if (sd_busy !== 1'b0) begin
      errors++;
      $display("FAIL cmd3_busy_len got busy=%b want 0 at T+1", sd_busy);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int cyc;
    int guard;
    bit cs_low;
    logic [7:0] resp;
    issue(2'd2, 8'h00);
    tick();
    load_card(8'h96);
    issue(2'd1, 8'h5A);
    guard = 0;
    while (pulses < 4 && guard < 500) begin
      tick();
      guard++;
    end
    checks++;
    if (pulses < 4) begin
      errors++;
      $display("FAIL midreset_wait got pulses=%0d want 4 within bound", pulses);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sd_din, sd_busy, sd_timeout, spi_sclk, spi_mosi, spi_cs_n} !== {8'hFF, 5'b00011}) begin
      errors++;
      $display("FAIL midreset_values got din=%h busy=%b tmo=%b sclk=%b mosi=%b cs_n=%b want ff 0 0 0 1 1",
               sd_din, sd_busy, sd_timeout, spi_sclk, spi_mosi, spi_cs_n);
    end
    tick();
    reset_n = 1'b1;
    tick();
    resp = 8'($urandom);
    run_xfer(8'h81, resp, cyc, cs_low);
    checks++;
    if (cyc !== XFER_CYC || sd_din !== resp || cs_low !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_xfer got cyc=%0d din=%h cs_low=%b want %0d %h 0",
               cyc, sd_din, cs_low, XFER_CYC, resp);
    end
  endtask

  initial begin
    test_reset();
    test_timeout_from_reset();
    test_cs_and_exchange();
    test_random_exchanges();
    test_init();
    test_long_strobe();
    test_cmd3_timeout();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
